// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
//   state_t    - scan FSM states (ST_GUARD, ST_SHOW)
//   SEG_BLANK  - all segments off (active-low)
//   GLYPH_TAB  - 16-entry hex glyph table, active-low abcdefg, entry i = glyph i
package seg7_pkg;

  typedef enum logic {
    ST_GUARD,
    ST_SHOW
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Concatenation lists glyph F first so that GLYPH_TAB[i] is glyph i.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational hex-to-7-segment decoder.
//   code - 4-bit value to display
//   seg  - active-low segments abcdefg
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_TAB[code];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with frame-synchronous shadow update.
//   clk, rst   - clock, asynchronous active-high reset
//   digits     - nibble i drives digit i (digit 0 rightmost)
//   dig_en     - per-digit enable, 0 blanks the digit
//   lzb_en     - leading-zero blanking enable (live)
//   upd_req    - request to load digits/dig_en into shadow registers
//   upd_ack    - one-cycle pulse when shadow registers are loaded
//   an         - active-low anode strobes
//   led        - active-low segments abcdefg
//   frame_tick - one-cycle pulse after each full scan
// Optional: define SEG7_DP_EN to add dp_in (captured with digits) and the
// active-low decimal-point output dp.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL_CYC  = 100000,
  parameter int unsigned GUARD_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    lzb_en,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              led,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic                    frame_tick
);

  localparam int unsigned CNT_MAX = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              led_q, led_d;
  logic                    upd_ack_q, upd_ack_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    boundary;
  logic                    load;
  logic                    visible;
  logic [NUM_DIGITS-1:0]   lzb;
  logic [6:0]              glyph;

  // Decoder looks at the digit that will be lit after this edge, so the
  // registered led lines up with the registered state.
  seg7_glyph_rom u_rom (
    .code (shadow_q[idx_d*4 +: 4]),
    .seg  (glyph)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_GUARD;
    endcase
  end

  // Leading-zero chain from the top: a digit is blankable while every
  // higher enabled digit is zero. Digit 0 is never blanked.
  always_comb begin
    logic above_ok;
    above_ok = 1'b1;
    lzb      = '0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      lzb[NUM_DIGITS-k] = above_ok && (shadow_q[(NUM_DIGITS-k)*4 +: 4] == 4'h0);
      above_ok = above_ok &&
                 (!en_sh_q[NUM_DIGITS-k] || (shadow_q[(NUM_DIGITS-k)*4 +: 4] == 4'h0));
    end
  end

  always_comb begin
    load         = boundary && upd_req;
    shadow_d     = shadow_q;
    en_sh_d      = en_sh_q;
    if (load) begin
      shadow_d = digits;
      en_sh_d  = dig_en;
    end
    upd_ack_d    = load;
    frame_tick_d = boundary;

    visible = (state_d == ST_SHOW) && en_sh_q[idx_d] && !(lzb_en && lzb[idx_d]);
    an_d    = '1;
    led_d   = SEG_BLANK;
    if (visible) begin
      an_d[idx_d] = 1'b0;
      led_d       = glyph;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      en_sh_q      <= '0;
      an_q         <= '1;
      led_q        <= SEG_BLANK;
      upd_ack_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      en_sh_q      <= en_sh_d;
      an_q         <= an_d;
      led_q        <= led_d;
      upd_ack_q    <= upd_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic                  dp_q, dp_d;

  always_comb begin
    dp_sh_d = load ? dp_in : dp_sh_q;
    dp_d    = visible ? ~dp_sh_q[idx_d] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_sh_q <= '0;
      dp_q    <= 1'b1;
    end else begin
      dp_sh_q <= dp_sh_d;
      dp_q    <= dp_d;
    end
  end

  assign dp = dp_q;
`endif

  assign an         = an_q;
  assign led        = led_q;
  assign upd_ack    = upd_ack_q;
  assign frame_tick = frame_tick_q;

endmodule
